// File: rtl/counter_gen_pkg.sv
// counter_gen_pkg
// Shared definitions for the counter_gen multi-mode counter.
// Mode encodings:
//   MODE_UP      (2'b00) count up by 1
//   MODE_DN      (2'b01) count down by 1
//   MODE_DN_STEP (2'b10) count down by STEP
//   MODE_LOAD    (2'b11) parallel load (clamped to the limit)
package counter_gen_pkg;

    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DN      = 2'b01,
        MODE_DN_STEP = 2'b10,
        MODE_LOAD    = 2'b11
    } mode_t;

endpackage : counter_gen_pkg

// File: rtl/counter_gen_next.sv
// counter_gen_next
// Purely combinational next-state calculator for counter_gen. Given the
// current count, the mode, the wrap limit and the load data it returns the
// next count and the flag values for one enabled cycle. Clear and enable
// are handled by the top.
//
// Optional build macro: COUNTER_GEN_SATURATE_EN
//   undefined : up/down/down-STEP wrap inside 0..limit
//   defined   : up stops at limit, down and down-STEP stop at 0
//
// Parameters:
//   WIDTH  count/data width (2..16)
//   STEP   decrement used by MODE_DN_STEP (1 .. 2**WIDTH-1)
// Ports:
//   q       in   current count
//   mode    in   operating mode (counter_gen_pkg::mode_t encoding)
//   limit   in   wrap limit, legal count range is 0..limit
//   d       in   parallel load data
//   next_q  out  count to register at the next edge
//   rco     out  wrap/borrow (or blocked step when saturating)
//   err     out  load clamp or out-of-range correction
//   load    out  load executed
module counter_gen_next
    import counter_gen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_q,
    output logic             rco,
    output logic             err,
    output logic             load
);

    localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

    // Non-wrapping step result; only used when q >= STEP so it never borrows.
    logic [WIDTH-1:0] step_diff;
    assign step_diff = q - STEP_N;

`ifndef COUNTER_GEN_SATURATE_EN
    // Wrapped step result q + (limit+1) - STEP. The sum is formed in WIDTH+1
    // bits so limit+1 cannot overflow when limit is all ones; the final
    // value is always <= limit and therefore fits back into WIDTH bits.
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   limit_ext;
    logic [WIDTH-1:0] wrap_sum;
    assign q_ext     = {1'b0, q};
    assign limit_ext = {1'b0, limit};
    assign wrap_sum  = WIDTH'(q_ext + limit_ext + (WIDTH+1)'(1) - STEP_EXT);
`endif

    always_comb begin
        next_q = q;
        rco    = 1'b0;
        err    = 1'b0;
        load   = 1'b0;

        if (mode == MODE_LOAD) begin
            load = 1'b1;
            if (d > limit) begin
                next_q = limit;
                err    = 1'b1;
            end else begin
                next_q = d;
            end
        end else if (q > limit) begin
            // Count left the legal range (limit lowered under it): snap back
            // to the end the counter is heading towards.
            err    = 1'b1;
            next_q = (mode == MODE_UP) ? '0 : limit;
        end else begin
            case (mode)
                MODE_UP: begin
                    if (q == limit) begin
`ifdef COUNTER_GEN_SATURATE_EN
                        next_q = limit;
`else
                        next_q = '0;
`endif
                        rco = 1'b1;
                    end else begin
                        next_q = q + WIDTH'(1);
                    end
                end
                MODE_DN: begin
                    if (q == '0) begin
`ifdef COUNTER_GEN_SATURATE_EN
                        next_q = '0;
`else
                        next_q = limit;
`endif
                        rco = 1'b1;
                    end else begin
                        next_q = q - WIDTH'(1);
                    end
                end
                MODE_DN_STEP: begin
`ifdef COUNTER_GEN_SATURATE_EN
                    if (q >= STEP_N) begin
                        next_q = step_diff;
                    end else begin
                        next_q = '0;
                        rco    = 1'b1;
                    end
`else
                    if (limit_ext < STEP_EXT - (WIDTH+1)'(1)) begin
                        // Range shorter than the step: no legal wrap target.
                        next_q = limit;
                        err    = 1'b1;
                    end else if (q >= STEP_N) begin
                        next_q = step_diff;
                    end else begin
                        next_q = wrap_sum;
                        rco    = 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule : counter_gen_next

// File: rtl/counter_gen.sv
// counter_gen
// Parametrised multi-mode counter with runtime wrap limit, load clamp and
// error flag. All outputs are registered. Holds the state registers and the
// clear/enable priority; the mode arithmetic lives in counter_gen_next.
//
// Optional build macro: COUNTER_GEN_SATURATE_EN (saturate instead of wrap).
//
// Parameters:
//   WIDTH  count/data width (2..16)
//   STEP   decrement for the down-STEP mode (1 .. 2**WIDTH-1)
// Ports:
//   cg_clk     in   clock, rising edge
//   cg_reset   in   asynchronous active-high reset
//   cg_enable  in   1 = execute cg_mode, 0 = hold
//   cg_clear   in   synchronous clear, wins over enable/mode
//   cg_mode    in   00 up+1, 01 down-1, 10 down-STEP, 11 load
//   cg_limit   in   wrap limit (count range 0..cg_limit)
//   cg_D       in   parallel load data
//   cg_Q       out  registered count
//   cg_load    out  1-cycle pulse, load executed
//   cg_rco     out  1-cycle pulse, wrap/borrow
//   cg_err     out  1-cycle pulse, clamp or range correction
module counter_gen
    import counter_gen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             cg_clk,
    input  logic             cg_reset,
    input  logic             cg_enable,
    input  logic             cg_clear,
    input  logic [1:0]       cg_mode,
    input  logic [WIDTH-1:0] cg_limit,
    input  logic [WIDTH-1:0] cg_D,
    output logic [WIDTH-1:0] cg_Q,
    output logic             cg_load,
    output logic             cg_rco,
    output logic             cg_err
);

    logic [WIDTH-1:0] q_reg;
    logic             load_reg;
    logic             rco_reg;
    logic             err_reg;

    logic [WIDTH-1:0] calc_q;
    logic             calc_rco;
    logic             calc_err;
    logic             calc_load;

    counter_gen_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .q      (q_reg),
        .mode   (cg_mode),
        .limit  (cg_limit),
        .d      (cg_D),
        .next_q (calc_q),
        .rco    (calc_rco),
        .err    (calc_err),
        .load   (calc_load)
    );

    // Flags are pulses: every branch that does not assert them drives 0.
    always_ff @(posedge cg_clk or posedge cg_reset) begin
        if (cg_reset) begin
            q_reg    <= '0;
            load_reg <= 1'b0;
            rco_reg  <= 1'b0;
            err_reg  <= 1'b0;
        end else if (cg_clear) begin
            q_reg    <= '0;
            load_reg <= 1'b0;
            rco_reg  <= 1'b0;
            err_reg  <= 1'b0;
        end else if (!cg_enable) begin
            load_reg <= 1'b0;
            rco_reg  <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            q_reg    <= calc_q;
            load_reg <= calc_load;
            rco_reg  <= calc_rco;
            err_reg  <= calc_err;
        end
    end

    assign cg_Q    = q_reg;
    assign cg_load = load_reg;
    assign cg_rco  = rco_reg;
    assign cg_err  = err_reg;

endmodule : counter_gen

// File: doc/counter_gen.md
Name: counter_gen

Overview:
Parametrised multi-mode counter: WIDTH bits, programmable STEP, runtime-programmable wrap limit. It succeeds the 4-bit fixed-mode counter in the same layout project family. Modes:
- count up by 1
- count down by 1
- count down by STEP
- parallel load

Additions over the fixed-mode counter: hold-on-disable, synchronous clear, a modulo limit, a load clamp and an error flag. All outputs are registered; the block drives layout-level counters and timers.

Parameters:
- WIDTH, 4, counter/data width in bits (2..16)
- STEP, 3, decrement for step-down mode (1 .. 2**WIDTH-1)

Ports:
- cg_clk  in  1  clock; all state changes on rising edge
- cg_reset  in  1  asynchronous, active-high reset
- cg_enable  in  1  1 = execute cg_mode this cycle; 0 = hold
- cg_clear  in  1  synchronous clear, priority over enable/mode
- cg_mode  in  2  00 up+1, 01 down-1, 10 down-STEP, 11 load
- cg_limit  in  WIDTH  wrap limit; count range is 0..cg_limit
- cg_D  in  WIDTH  parallel load data
- cg_Q  out  WIDTH  registered count
- cg_load  out  1  1-cycle pulse: load executed
- cg_rco  out  1  1-cycle pulse: wrap/borrow occurred
- cg_err  out  1  1-cycle pulse: clamp or out-of-range correction

Behaviour:
- Interface (decided): one clock, cg_clk; reset cg_reset is asynchronous and active-high.
- Reset: cg_Q=0, cg_load=0, cg_rco=0, cg_err=0, applied immediately without a clock edge. Reset mid-operation discards the count. First update occurs on the first rising edge after deassertion.
- Latency: inputs sampled at a rising edge; results visible on cg_Q and flags after that same edge. Flags are 0 in any cycle not asserting them.
- Priority, highest first: cg_reset > cg_clear > cg_enable=0 > mode.
- cg_clear=1: cg_Q<=0, all flags 0, regardless of enable or mode.
- cg_enable=0: cg_Q holds; all flags 0. This is not a clear.
- Range correction (enabled, modes 00/01/10, cg_Q > cg_limit, e.g. limit lowered mid-count):
  - cg_Q<=0 in mode 00, cg_Q<=cg_limit in modes 01/10
  - cg_err=1, cg_rco=0
- Mode 00, up: cg_Q==cg_limit -> cg_Q<=0, cg_rco=1; else cg_Q+1, cg_rco=0.
- Mode 01, down: cg_Q==0 -> cg_Q<=cg_limit, cg_rco=1; else cg_Q-1.
- Mode 10, down-STEP:
  - cg_Q>=STEP -> cg_Q-STEP, cg_rco=0
  - otherwise cg_Q + (cg_limit+1) - STEP, cg_rco=1
  - arithmetic in WIDTH+1 bits; no truncation before the final result
  - if cg_limit < STEP-1 the step cannot wrap legally: cg_Q<=cg_limit, cg_err=1, cg_rco=0
- Mode 11, load: cg_Q<=min(cg_D, cg_limit), cg_load=1, cg_rco=0. cg_err=1 if cg_D > cg_limit.
- cg_limit=0: up/down modes hold at 0 with cg_rco=1 every enabled cycle.
- cg_limit = 2**WIDTH-1: natural binary wrap.

Optional Feature:
- Macro: COUNTER_GEN_SATURATE_EN.
- Defined: modes 00/01/10 saturate instead of wrapping.
  - up stops at cg_limit
  - down and down-STEP stop at 0
  - cg_rco=1 on every enabled cycle where the step was blocked or truncated
- Undefined: wrap behaviour as above. Load and clear are identical in both builds.

Decomposition:
- Package counter_gen_pkg: mode constants MODE_UP=2'b00, MODE_DN=2'b01, MODE_DN_STEP=2'b10, MODE_LOAD=2'b11.
- One combinational sub-module, counter_gen_next: takes Q, mode, limit, D; returns next_q, rco, err, load.
- The top holds registers, priority and enable logic only.

Test Plan:
- WIDTH=4, limit=15, up from 7, assert cg_reset between edges -> cg_Q=0 immediately; after release, up counting resumes 0,1,2.
- limit=9, mode 00 from Q=8 -> Q=9 (rco 0), then Q=0 with rco=1 for exactly one cycle, then Q=1.
- limit=15, mode 10: Q=5->2 (rco 0), 2->15 (rco 1). With limit=9: Q=1->8 (rco 1). With limit=1: Q=1->1 (err 1).
- limit=9, mode 11, D=12 -> Q=9, load=1, err=1. D=4 -> Q=4, load=1, err=0.
- Q=5, enable=0 for 3 cycles -> Q stays 5, flags 0. Then clear=1 with enable=1, mode 11 -> Q=0, load=0.
- COUNTER_GEN_SATURATE_EN defined, limit=15, Q=15, mode 00 for 2 cycles -> Q=15, rco=1 both cycles. Mode 10 from Q=2 -> Q=0, rco=1.
